fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter sequencer for the 2-stage pipelined MIPS core. It drives the word address and read enable of the synchronous instruction memory inside the fetch unit, and tags each returned instruction with its PC and a valid bit. It applies decode-stage redirects (branch, jump), stalls and halt, and inserts one squash bubble after every taken redirect.

Parameters:
RESET_PC, 32'h0000_0000, byte PC after reset; bits [1:0] are ignored and treated as 0.
ADDR_W, 8, instruction-memory word-address width (256 words).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  decode stage cannot accept; hold fetch state.
branch_taken  in  1  instruction at fetch_pc is a taken branch.
branch_offset  in  16  signed word offset of the branch (inst[15:0]).
jump  in  1  instruction at fetch_pc is a jump.
jump_index  in  26  jump target index (inst[25:0]).
halt  in  1  instruction at fetch_pc is a halt.
imem_addr  out  ADDR_W  word address to instruction memory, equal to pc[ADDR_W+1:2].
imem_en  out  1  instruction memory read enable; the memory registers its output on clk when this is 1.
fetch_pc  out  32  byte PC of the instruction currently output by memory.
if_valid  out  1  memory output is a valid instruction for decode.
flush  out  1  high during the squash-bubble cycle.
halted  out  1  sequencer is halted.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Internal registers: pc (32-bit), state in {BOOT, RUN, FLUSH, HALT}.
- Reset values: pc = RESET_PC & ~3, fetch_pc = RESET_PC & ~3, if_valid = 0, flush = 0, halted = 0, state = BOOT. imem_addr follows pc combinationally.
- Memory latency is 1 cycle: the address presented in cycle N returns data in cycle N+1, tagged with fetch_pc and if_valid.
- imem_en is combinational: 1 in BOOT and FLUSH; ~stall in RUN; 0 in HALT.
- BOOT: stall is ignored. On the clock edge: fetch_pc <= pc, pc <= pc+4, if_valid <= 1, state <= RUN.
- FLUSH: if_valid = 0, flush = 1, and stall and all event inputs are ignored. Same update as BOOT; next state is RUN, where flush returns to 0.
- RUN with stall = 1: pc, fetch_pc, if_valid and state hold. halt, jump and branch_taken are not sampled; decode keeps them asserted until stall drops.
- RUN with stall = 0, evaluated in priority order halt > jump > branch_taken > sequential:
  - halt: state <= HALT, if_valid <= 0, halted <= 1, pc holds.
  - jump: pc <= {(fetch_pc+4)[31:28], jump_index, 2'b00}.
  - branch_taken: pc <= fetch_pc + 4 + (sign_extend(branch_offset) << 2).
  - For jump and branch: if_valid <= 0 and state <= FLUSH. The word fetched this cycle (fetch_pc+4) is squashed; there is no delay slot.
  - sequential: fetch_pc <= pc, pc <= pc+4, if_valid stays 1.
- HALT: absorbing. All inputs are ignored, imem_en = 0, if_valid = 0, halted = 1. Only rst_n exits HALT.
- Arithmetic: all PC arithmetic is modulo 2^32 with no overflow detection. imem_addr wraps naturally at 2^ADDR_W words.
- Event inputs are qualified by if_valid: whenever if_valid = 0 they have no effect.
- Reset asserted mid-operation, including during FLUSH, stall or HALT: all registers return to reset values immediately, without waiting for a clock edge.

Test Plan:
1. ADDR_W=8, RESET_PC=0; release reset, no events -> imem_addr 0,1,2,3,... on successive cycles; if_valid 0 in the first cycle then 1; fetch_pc 0x0, 0x4, 0x8, ...
2. At fetch_pc=0x8, branch_taken=1, branch_offset=16'hFFFE -> next cycle if_valid=0, flush=1, imem_addr=1. The following cycle fetch_pc=0x4, if_valid=1, flush=0.
3. At fetch_pc=0x10, jump=1 and branch_taken=1 with jump_index=26'h40 -> jump wins: imem_addr=0x40 after the edge, then fetch_pc=0x100 with if_valid=1 after the bubble.
4. At fetch_pc=0xC, stall high 3 cycles with branch_taken pulsed during the stall -> imem_en=0, fetch_pc, imem_addr and if_valid frozen, branch ignored. After release, fetch_pc=0x10 follows sequentially.
5. At fetch_pc=0x14, halt=1 -> next cycle halted=1, if_valid=0, imem_en=0 indefinitely; a later jump has no effect. Asserting rst_n=0 between clock edges -> outputs return to reset values immediately, and BOOT sequence resumes after release.
6. RESET_PC=32'hFFFF_FFFC -> imem_addr 0xFF then 0x00; fetch_pc 0xFFFF_FFFC then 0x0000_0000 with no error indication.

Source files
------------

// File: rtl/fetch_sequencer.sv
// PC sequencer for the 2-stage MIPS fetch unit: drives the synchronous imem,
// tags its output with PC/valid, applies redirects, stalls and halt.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              halt,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  output logic [31:0]       fetch_pc,
  output logic              if_valid,
  output logic              flush,
  output logic              halted
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

  localparam logic [31:0] PC0 = RESET_PC & 32'hFFFF_FFFC;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] seq_pc, br_tgt, jmp_tgt;

  // Redirect targets are relative to the word after the one at fetch_pc.
  assign seq_pc  = fetch_pc + 32'd4;
  assign br_tgt  = seq_pc + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jmp_tgt = {seq_pc[31:28], jump_index, 2'b00};

  assign imem_addr = pc[ADDR_W+1:2];

  always_comb begin
    imem_en = 1'b0;
    case (state)
      BOOT, FLUSH: imem_en = 1'b1;
      RUN:         imem_en = ~stall;
      default:     imem_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= PC0;
      fetch_pc <= PC0;
      if_valid <= 1'b0;
      flush    <= 1'b0;
      halted   <= 1'b0;
      state    <= BOOT;
    end else begin
      case (state)
        BOOT, FLUSH: begin
          fetch_pc <= pc;
          pc       <= pc + 32'd4;
          if_valid <= 1'b1;
          flush    <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          if (!stall) begin
            if (if_valid && halt) begin
              if_valid <= 1'b0;
              halted   <= 1'b1;
              state    <= HALT;
            end else if (if_valid && jump) begin
              pc       <= jmp_tgt;
              if_valid <= 1'b0;
              flush    <= 1'b1;
              state    <= FLUSH;
            end else if (if_valid && branch_taken) begin
              pc       <= br_tgt;
              if_valid <= 1'b0;
              flush    <= 1'b1;
              state    <= FLUSH;
            end else begin
              fetch_pc <= pc;
              pc       <= pc + 32'd4;
            end
          end
        end
        default: begin
          if_valid <= 1'b0;
          halted   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan steps then random traffic on two
// instances (reset PC 0 and a wrapping, misaligned reset PC) against a cycle model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, stall, branch_taken, jump, halt;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;

  logic [7:0]  d0_addr, d1_addr;
  logic        d0_en, d0_vld, d0_fl, d0_hlt;
  logic        d1_en, d1_vld, d1_fl, d1_hlt;
  logic [31:0] d0_fpc, d1_fpc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .ADDR_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index), .halt(halt),
    .imem_addr(d0_addr), .imem_en(d0_en), .fetch_pc(d0_fpc), .if_valid(d0_vld),
    .flush(d0_fl), .halted(d0_hlt));

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFF), .ADDR_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_index(jump_index), .halt(halt),
    .imem_addr(d1_addr), .imem_en(d1_en), .fetch_pc(d1_fpc), .if_valid(d1_vld),
    .flush(d1_fl), .halted(d1_hlt));

  // Model: next PC to fetch, the tagged output, and three mode flags.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] fpc;
    bit          vld;
    bit          bubble;
    bit          stopped;
    bit          booting;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t minit(input logic [31:0] rp);
    mdl_t m;
    m.pc = {rp[31:2], 2'b00};
    m.fpc = m.pc;
    m.vld = 0; m.bubble = 0; m.stopped = 0; m.booting = 1;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit s, input bit bt, input logic [15:0] bo,
                                 input bit j, input logic [25:0] ji, input bit h);
    mdl_t n = m;
    longint off;
    if (m.stopped) return n;
    if (m.booting || m.bubble) begin
      n.fpc = m.pc; n.pc = m.pc + 4; n.vld = 1; n.bubble = 0; n.booting = 0;
    end else if (s || !m.vld) begin
      // frozen
    end else if (h) begin
      n.stopped = 1; n.vld = 0;
    end else if (j) begin
      n.pc = ((m.fpc + 4) & 32'hF000_0000) | (32'(ji) * 4);
      n.vld = 0; n.bubble = 1;
    end else if (bt) begin
      off = longint'($signed(bo)) * 4;
      n.pc = 32'(longint'(m.fpc) + 4 + off);
      n.vld = 0; n.bubble = 1;
    end else begin
      n.fpc = m.pc; n.pc = m.pc + 4;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string t, input mdl_t m, input bit s, input logic [7:0] a,
                         input logic en, input logic [31:0] fpc, input logic v,
                         input logic fl, input logic hl);
    chk({t, "_addr"},   {24'b0, a}, (m.pc >> 2) & 32'hFF);
    chk({t, "_en"},     {31'b0, en}, {31'b0, !m.stopped && (m.booting || m.bubble || !s)});
    chk({t, "_fpc"},    fpc, m.fpc);
    chk({t, "_vld"},    {31'b0, v}, {31'b0, m.vld});
    chk({t, "_flush"},  {31'b0, fl}, {31'b0, m.bubble});
    chk({t, "_halted"}, {31'b0, hl}, {31'b0, m.stopped});
  endtask

  // One cycle: drive inputs at the negedge, check settled outputs, advance model.
  task automatic cyc(input bit r, input bit s, input bit bt, input logic [15:0] bo,
                     input bit j, input logic [25:0] ji, input bit h);
    rst_n = r; stall = s; branch_taken = bt; branch_offset = bo;
    jump = j; jump_index = ji; halt = h;
    #1;
    if (!r) begin
      m0 = minit(32'h0000_0000);
      m1 = minit(32'hFFFF_FFFF);
    end
    chk_dut("d0", m0, s, d0_addr, d0_en, d0_fpc, d0_vld, d0_fl, d0_hlt);
    chk_dut("d1", m1, s, d1_addr, d1_en, d1_fpc, d1_vld, d1_fl, d1_hlt);
    if (r) begin
      m0 = mstep(m0, s, bt, bo, j, ji, h);
      m1 = mstep(m1, s, bt, bo, j, ji, h);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; stall = 0; branch_taken = 0; branch_offset = '0;
    jump = 0; jump_index = '0; halt = 0;
    m0 = minit(32'h0000_0000);
    m1 = minit(32'hFFFF_FFFF);
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_fpc1", d1_fpc, 32'hFFFF_FFFC);
    chk("rst_addr1", {24'b0, d1_addr}, 32'hFF);

    cyc(1, 0, 0, 0, 0, 0, 0);                // boot, fetch_pc 0 invalid
    cyc(1, 0, 0, 0, 0, 0, 0);                // fetch_pc 0
    chk("wrap_fpc", d1_fpc, 32'h0000_0000);
    chk("wrap_addr", {24'b0, d1_addr}, 32'h1);
    cyc(1, 0, 0, 0, 0, 0, 0);                // fetch_pc 4
    cyc(1, 0, 1, 16'hFFFE, 0, 0, 0);         // fetch_pc 8, branch back to 4
    chk("br_flush", {31'b0, d0_fl}, 32'h1);
    chk("br_addr", {24'b0, d0_addr}, 32'h1);
    cyc(1, 0, 0, 0, 0, 0, 0);                // bubble
    chk("br_fpc", d0_fpc, 32'h4);
    chk("br_vld", {31'b0, d0_vld}, 32'h1);
    cyc(1, 0, 0, 0, 0, 0, 0);                // fetch_pc 4
    cyc(1, 0, 0, 0, 0, 0, 0);                // fetch_pc 8
    cyc(1, 1, 0, 0, 0, 0, 0);                // fetch_pc C stalled
    cyc(1, 1, 1, 16'h0020, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("stall_fpc", d0_fpc, 32'hC);
    cyc(1, 0, 0, 0, 0, 0, 0);                // released
    chk("stall_seq", d0_fpc, 32'h10);
    cyc(1, 0, 1, 16'h0005, 1, 26'h40, 0);    // jump beats branch
    chk("jmp_addr", {24'b0, d0_addr}, 32'h40);
    cyc(1, 0, 0, 0, 0, 0, 0);                // bubble
    chk("jmp_fpc", d0_fpc, 32'h100);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);                // halt
    chk("halt_hl", {31'b0, d0_hlt}, 32'h1);
    cyc(1, 0, 0, 0, 1, 26'h3, 0);            // jump ignored in HALT
    cyc(1, 1, 1, 16'h1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);                // async reset between edges
    cyc(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      bit r = ($urandom_range(0, 59) != 0);
      cyc(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 16'($urandom),
          ($urandom_range(0, 9) == 0), 26'($urandom), ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
